// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type codes, injector FSM states and head-flit builder.
package noc_pkg;

  localparam logic [1:0] FLIT_NONE = 2'b00;
  localparam logic [1:0] FLIT_HEAD = 2'b01;
  localparam logic [1:0] FLIT_BODY = 2'b10;
  localparam logic [1:0] FLIT_TAIL = 2'b11;

  typedef enum logic {
    StIdle,
    StPayload
  } injState_t;

  // Builds a head flit in a 64-bit container; callers truncate to their flit width.
  // Type in the top typeWidth bits, dest just below it, src just below dest, rest zero.
  function automatic logic [63:0] make_head(input logic [31:0] dest, input logic [31:0] src,
                                            input int unsigned idw, input int unsigned dataWidth,
                                            input int unsigned typeWidth);
    logic [63:0] mask;
    logic [63:0] head;
    mask = (64'd1 << idw) - 64'd1;
    head = 64'(FLIT_HEAD) << (dataWidth - typeWidth);
    head = head | ((64'(dest) & mask) << (dataWidth - typeWidth - idw));
    head = head | ((64'(src) & mask) << (dataWidth - typeWidth - 2 * idw));
    return head;
  endfunction

endpackage

// File: rtl/flit_out_reg.sv
// Valid/ready output register: loads only when the slot is free, holds under backpressure.
module flit_out_reg #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [Width-1:0] loadData,
  input  logic             readyOut,
  output logic             slotFree,
  output logic             validOut,
  output logic [Width-1:0] dataOut
);

  logic             validQ;
  logic [Width-1:0] dataQ;

  // Slot is free when empty or when the held flit is being taken this cycle.
  always_comb begin
    slotFree = !validQ || readyOut;
  end

  // Output register; an empty free slot with no load drops valid but keeps stale data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      validQ <= 1'b0;
      dataQ  <= '0;
    end else if (slotFree) begin
      validQ <= load;
      if (load) begin
        dataQ <= loadData;
      end
    end
  end

  assign validOut = validQ;
  assign dataOut  = dataQ;

endmodule

// File: rtl/packet_injector.sv
// Source-side packetizer: one HEAD flit then FlitPerPacket-1 payload flits, last one TAIL.
module packet_injector
  import noc_pkg::*;
#(
  parameter int unsigned N             = 4,
  parameter int unsigned INDEX         = 1,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned TYPE_WIDTH    = 2,
  parameter int unsigned FlitPerPacket = 6,
  parameter int unsigned CNT_WIDTH     = 16,
  localparam int unsigned IDW          = $clog2(N),
  localparam int unsigned PW           = DATA_WIDTH - TYPE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pkt_valid,
  output logic                  pkt_ready,
  input  logic [IDW-1:0]        pkt_dest,
  input  logic                  pl_valid,
  output logic                  pl_ready,
  input  logic [PW-1:0]         pl_data,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic                  ready_out,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  pkt_sent_count
);

  localparam int unsigned CW = $clog2(FlitPerPacket);

  injState_t             stateQ, stateD;
  logic [CW-1:0]         cntQ, cntD;
  logic [CNT_WIDTH-1:0]  sentQ;
  logic                  slotFree;
  logic                  load;
  logic [DATA_WIDTH-1:0] loadData;
  logic [DATA_WIDTH-1:0] headFlit;
  logic                  isTail;
  logic                  tailTaken;

  assign headFlit = DATA_WIDTH'(make_head(32'(pkt_dest), 32'(INDEX), IDW, DATA_WIDTH, TYPE_WIDTH));
  assign isTail   = (cntQ == CW'(FlitPerPacket - 2));

  // Next-state, counter and register-load decode; requests/words accepted only into a free slot.
  always_comb begin
    stateD    = stateQ;
    cntD      = cntQ;
    load      = 1'b0;
    loadData  = headFlit;
    pkt_ready = 1'b0;
    pl_ready  = 1'b0;
    unique case (stateQ)
      StIdle: begin
        pkt_ready = slotFree;
        if (pkt_valid && slotFree) begin
          load     = 1'b1;
          loadData = headFlit;
          cntD     = '0;
          stateD   = StPayload;
        end
      end
      StPayload: begin
        pl_ready = slotFree;
        if (pl_valid && slotFree) begin
          load     = 1'b1;
          loadData = {TYPE_WIDTH'(isTail ? FLIT_TAIL : FLIT_BODY), pl_data};
          cntD     = cntQ + CW'(1);
          if (isTail) begin
            stateD = StIdle;
          end
        end
      end
      default: ;
    endcase
  end

  // FSM state and flit counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateQ <= StIdle;
      cntQ   <= '0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
    end
  end

  flit_out_reg #(
    .Width(DATA_WIDTH)
  ) u_out_reg (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .loadData(loadData),
    .readyOut(ready_out),
    .slotFree(slotFree),
    .validOut(valid_out),
    .dataOut (data_out)
  );

  assign tailTaken = valid_out && ready_out &&
                     (data_out[DATA_WIDTH-1 -: TYPE_WIDTH] == TYPE_WIDTH'(FLIT_TAIL));

  // Completed-packet counter, bumped when a TAIL flit is handed off; wraps naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sentQ <= '0;
    end else if (tailTaken) begin
      sentQ <= sentQ + CNT_WIDTH'(1);
    end
  end

  assign pkt_sent_count = sentQ;
  assign busy           = (stateQ != StIdle) || valid_out;

endmodule
